// File: rtl/usb3_ep_dbuf_if.sv
// usb3_ep_dbuf_if: link-side write/commit and user-side read/release
// bundle for the ping-pong endpoint buffer.
interface usb3_ep_dbuf_if #(
    parameter int ADDR_W = 9
);
    localparam int LEN_W = ADDR_W + 3;

    logic [ADDR_W-1:0] link_wr_addr;
    logic [31:0]       link_wr_data;
    logic              link_wr_en;
    logic              link_ready;
    logic              link_commit;
    logic [LEN_W-1:0]  link_commit_len;
    logic              link_commit_ack;
    logic [ADDR_W-1:0] usr_rd_addr;
    logic [31:0]       usr_rd_q;
    logic [LEN_W-1:0]  usr_len;
    logic              usr_hasdata;
    logic              usr_release;
    logic              usr_release_ack;
    logic [1:0]        buf_count;
    logic              err_overrun;
    logic              err_underrun;

    modport master (
        output link_wr_addr, link_wr_data, link_wr_en,
        output link_commit, link_commit_len,
        output usr_rd_addr, usr_release,
        input  link_ready, link_commit_ack,
        input  usr_rd_q, usr_len, usr_hasdata, usr_release_ack,
        input  buf_count, err_overrun, err_underrun
    );

    modport slave (
        input  link_wr_addr, link_wr_data, link_wr_en,
        input  link_commit, link_commit_len,
        input  usr_rd_addr, usr_release,
        output link_ready, link_commit_ack,
        output usr_rd_q, usr_len, usr_hasdata, usr_release_ack,
        output buf_count, err_overrun, err_underrun
    );
endinterface

// File: rtl/usb3_ep_dbuf.sv
// usb3_ep_dbuf: ping-pong (or single) endpoint buffer with commit and
// release handshakes, occupancy count and overrun/underrun pulses.
module usb3_ep_dbuf #(
    parameter int ADDR_W   = 9,
    parameter int DUAL_BUF = 1,
    parameter int ACK_CYC  = 4
) (
    input logic           local_clk,
    input logic           reset_n,
    usb3_ep_dbuf_if.slave bus
);
    localparam int LEN_W  = ADDR_W + 3;
    localparam int NBUF   = 1 + DUAL_BUF;
    localparam int RAM_AW = ADDR_W + DUAL_BUF;
    localparam int CW     = (ACK_CYC > 1) ? $clog2(ACK_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACK_CYC - 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << (ADDR_W + 2);

    typedef enum logic {C_IDLE, C_ACK} cst_t;
    typedef enum logic {R_IDLE, R_ACK} rst_t;

    cst_t             cstate_q, cstate_d;
    rst_t             rstate_q, rstate_d;
    logic [CW-1:0]    ccnt_q, ccnt_d;
    logic [CW-1:0]    rcnt_q, rcnt_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       full_q, full_d;
    logic [LEN_W-1:0] len_q [2];
    logic [LEN_W-1:0] len_d [2];
    logic [1:0]       csync_q, csync_d;
    logic [1:0]       rsync_q, rsync_d;
    logic             ovr_q, ovr_d;
    logic             und_q, und_d;
    logic [31:0]      rd_data_q;

    logic [31:0]      mem [NBUF << ADDR_W];
    logic [ADDR_W:0]  wr_idx;
    logic [ADDR_W:0]  rd_idx;
    logic             c_edge;
    logic             r_edge;
    logic             ready;
    logic [LEN_W-1:0] clamp_len;

    assign wr_idx    = {wr_ptr_q, bus.link_wr_addr};
    assign rd_idx    = {rd_ptr_q, bus.usr_rd_addr};
    assign c_edge    = csync_q[0] & ~csync_q[1];
    assign r_edge    = rsync_q[0] & ~rsync_q[1];
    assign ready     = (cstate_q == C_IDLE) & ~full_q[wr_ptr_q];
    assign clamp_len = (bus.link_commit_len > MAX_LEN) ?
                       MAX_LEN : bus.link_commit_len;

    // Next-state for both handshake FSMs, flags, lengths and pointers.
    always_comb begin
        cstate_d = cstate_q;
        rstate_d = rstate_q;
        ccnt_d   = ccnt_q;
        rcnt_d   = rcnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full_d   = full_q;
        len_d    = len_q;
        csync_d  = {csync_q[0], bus.link_commit};
        rsync_d  = {rsync_q[0], bus.usr_release};
        ovr_d    = 1'b0;
        und_d    = 1'b0;

        unique case (cstate_q)
            C_IDLE: begin
                if (c_edge) begin
                    if (!full_q[wr_ptr_q]) begin
                        len_d[wr_ptr_q]  = clamp_len;
                        full_d[wr_ptr_q] = 1'b1;
                        ccnt_d           = '0;
                        cstate_d         = C_ACK;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            C_ACK: begin
                if (ccnt_q == LAST) begin
                    if (DUAL_BUF != 0) wr_ptr_d = ~wr_ptr_q;
                    cstate_d = C_IDLE;
                end else begin
                    ccnt_d = ccnt_q + CW'(1);
                end
            end
        endcase

        unique case (rstate_q)
            R_IDLE: begin
                if (r_edge) begin
                    if (full_q[rd_ptr_q]) begin
                        rcnt_d   = '0;
                        rstate_d = R_ACK;
                    end else begin
                        und_d = 1'b1;
                    end
                end
            end
            R_ACK: begin
                if (rcnt_q == LAST) begin
                    full_d[rd_ptr_q] = 1'b0;
                    if (DUAL_BUF != 0) rd_ptr_d = ~rd_ptr_q;
                    rstate_d = R_IDLE;
                end else begin
                    rcnt_d = rcnt_q + CW'(1);
                end
            end
        endcase
    end

    // Control state registers with synchronous reset; aborts any ack.
    always_ff @(posedge local_clk) begin
        if (!reset_n) begin
            cstate_q <= C_IDLE;
            rstate_q <= R_IDLE;
            ccnt_q   <= '0;
            rcnt_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            full_q   <= '0;
            len_q    <= '{default: '0};
            csync_q  <= '0;
            rsync_q  <= '0;
            ovr_q    <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            cstate_q <= cstate_d;
            rstate_q <= rstate_d;
            ccnt_q   <= ccnt_d;
            rcnt_q   <= rcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            len_q    <= len_d;
            csync_q  <= csync_d;
            rsync_q  <= rsync_d;
            ovr_q    <= ovr_d;
            und_q    <= und_d;
        end
    end

    // Packet RAM: gated write port, registered read port.
    always_ff @(posedge local_clk) begin
        if (bus.link_wr_en && ready)
            mem[wr_idx[RAM_AW-1:0]] <= bus.link_wr_data;
        rd_data_q <= mem[rd_idx[RAM_AW-1:0]];
    end

    assign bus.link_ready      = ready;
    assign bus.link_commit_ack = (cstate_q == C_ACK);
    assign bus.usr_release_ack = (rstate_q == R_ACK);
    assign bus.usr_hasdata     = full_q[rd_ptr_q];
    assign bus.usr_len         = len_q[rd_ptr_q];
    assign bus.usr_rd_q        = rd_data_q;
    assign bus.buf_count       = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    assign bus.err_overrun     = ovr_q;
    assign bus.err_underrun    = und_q;
endmodule

// File: tb/tb_usb3_ep_dbuf.sv
// tb_usb3_ep_dbuf: directed stimulus on a dual and a single buffer
// instance; a negedge monitor scores pulses and reads against a queue.
module tb_usb3_ep_dbuf;
    localparam int K_CACK = 0;
    localparam int K_RACK = 1;
    localparam int K_OVR  = 2;
    localparam int K_UND  = 3;
    localparam int K_RD   = 4;

    typedef struct {
        int          dut;
        int          kind;
        logic [31:0] val;
    } ev_t;

    logic clk;
    logic reset_n;

    logic        commit  [2];
    logic        rel     [2];
    logic        wr_en   [2];
    logic [3:0]  wr_addr [2];
    logic [31:0] wr_data [2];
    logic [6:0]  clen    [2];
    logic [3:0]  rd_addr [2];
    logic        rd_vld  [2];
    logic        rd_vld_q[2];

    logic [31:0] rd_q    [2];
    logic [3:0]  pul     [2];
    logic        ready   [2];
    logic        hasdata [2];
    logic [6:0]  ulen    [2];
    logic [1:0]  bcnt    [2];

    ev_t exp_q[$];
    int  cnt[2][4];
    int  checks = 0;
    int  errors = 0;

    usb3_ep_dbuf_if #(.ADDR_W(4)) ia ();
    usb3_ep_dbuf_if #(.ADDR_W(4)) ib ();

    usb3_ep_dbuf #(.ADDR_W(4), .DUAL_BUF(1), .ACK_CYC(4)) dut_a (
        .local_clk(clk),
        .reset_n  (reset_n),
        .bus      (ia)
    );

    usb3_ep_dbuf #(.ADDR_W(4), .DUAL_BUF(0), .ACK_CYC(3)) dut_b (
        .local_clk(clk),
        .reset_n  (reset_n),
        .bus      (ib)
    );

    assign ia.link_wr_addr    = wr_addr[0];
    assign ia.link_wr_data    = wr_data[0];
    assign ia.link_wr_en      = wr_en[0];
    assign ia.link_commit     = commit[0];
    assign ia.link_commit_len = clen[0];
    assign ia.usr_rd_addr     = rd_addr[0];
    assign ia.usr_release     = rel[0];
    assign ib.link_wr_addr    = wr_addr[1];
    assign ib.link_wr_data    = wr_data[1];
    assign ib.link_wr_en      = wr_en[1];
    assign ib.link_commit     = commit[1];
    assign ib.link_commit_len = clen[1];
    assign ib.usr_rd_addr     = rd_addr[1];
    assign ib.usr_release     = rel[1];

    assign rd_q[0]    = ia.usr_rd_q;
    assign rd_q[1]    = ib.usr_rd_q;
    assign pul[0]     = {ia.err_underrun, ia.err_overrun,
                         ia.usr_release_ack, ia.link_commit_ack};
    assign pul[1]     = {ib.err_underrun, ib.err_overrun,
                         ib.usr_release_ack, ib.link_commit_ack};
    assign ready[0]   = ia.link_ready;
    assign ready[1]   = ib.link_ready;
    assign hasdata[0] = ia.usr_hasdata;
    assign hasdata[1] = ib.usr_hasdata;
    assign ulen[0]    = ia.usr_len;
    assign ulen[1]    = ib.usr_len;
    assign bcnt[0]    = ia.buf_count;
    assign bcnt[1]    = ib.buf_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Marks the cycle in which a presented read address returns data.
    always @(posedge clk) begin
        rd_vld_q[0] <= rd_vld[0];
        rd_vld_q[1] <= rd_vld[1];
    end

    function automatic void push(int d, int k, logic [31:0] v);
        ev_t e;
        e.dut  = d;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    function automatic void sb(int d, int k, logic [31:0] v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: dut %0d kind %0d got %0h want none",
                     d, k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.dut != d || e.kind != k || e.val !== v) begin
                errors++;
                $display("FAIL sb_event: got dut %0d kind %0d val %0h want dut %0d kind %0d val %0h",
                         d, k, v, e.dut, e.kind, e.val);
            end
        end
    endfunction

    // Monitor: pulse widths scored on the falling edge of each pulse,
    // read data scored one cycle after the address was presented.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 4; s++) begin
                if (pul[d][s] === 1'b1) begin
                    cnt[d][s]++;
                end else if (cnt[d][s] != 0) begin
                    sb(d, s, 32'(cnt[d][s]));
                    cnt[d][s] = 0;
                end
            end
            if (rd_vld_q[d]) sb(d, K_RD, rd_q[d]);
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(int d, logic [3:0] a, logic [31:0] v);
        wr_en[d]   = 1'b1;
        wr_addr[d] = a;
        wr_data[d] = v;
        cyc(1);
        wr_en[d] = 1'b0;
    endtask

    task automatic rd(int d, logic [3:0] a, logic [31:0] v);
        push(d, K_RD, v);
        rd_addr[d] = a;
        rd_vld[d]  = 1'b1;
        cyc(1);
        rd_vld[d] = 1'b0;
        cyc(1);
    endtask

    task automatic pcommit(int d, logic [6:0] l);
        clen[d]   = l;
        commit[d] = 1'b1;
        cyc(2);
        commit[d] = 1'b0;
        cyc(4);
    endtask

    task automatic prel(int d);
        rel[d] = 1'b1;
        cyc(2);
        rel[d] = 1'b0;
        cyc(4);
    endtask

    initial begin
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            commit[d]   = 1'b0;
            rel[d]      = 1'b0;
            wr_en[d]    = 1'b0;
            wr_addr[d]  = '0;
            wr_data[d]  = '0;
            clen[d]     = '0;
            rd_addr[d]  = '0;
            rd_vld[d]   = 1'b0;
            rd_vld_q[d] = 1'b0;
            for (int s = 0; s < 4; s++) cnt[d][s] = 0;
        end
        cyc(3);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(ready[d]), 1);
            chk("rst_hasdata", 32'(hasdata[d]), 0);
            chk("rst_len", 32'(ulen[d]), 0);
            chk("rst_bcnt", 32'(bcnt[d]), 0);
            chk("rst_pulses", 32'(pul[d]), 0);
        end
        reset_n = 1'b1;
        cyc(2);

        // single packet, exact ack window
        for (int i = 0; i < 4; i++) wr(0, 4'(i), 32'hA000_0000 + i);
        push(0, K_CACK, 4);
        clen[0]   = 7'd16;
        commit[0] = 1'b1;
        cyc(1);
        chk("t1_ack_n1", 32'(pul[0][0]), 0);
        cyc(1);
        chk("t1_ack_n2", 32'(pul[0][0]), 1);
        chk("t1_ready_ack", 32'(ready[0]), 0);
        chk("t1_hasdata", 32'(hasdata[0]), 1);
        chk("t1_len", 32'(ulen[0]), 16);
        commit[0] = 1'b0;
        cyc(3);
        chk("t1_ack_n5", 32'(pul[0][0]), 1);
        cyc(1);
        chk("t1_ack_n6", 32'(pul[0][0]), 0);
        chk("t1_ready_n6", 32'(ready[0]), 1);
        rd(0, 4'd2, 32'hA000_0002);
        push(0, K_RACK, 4);
        prel(0);
        chk("t1_bcnt_rel", 32'(bcnt[0]), 0);

        // ping-pong with overrun and gated write
        wr(0, 4'd0, 32'hB1B1_B1B1);
        push(0, K_CACK, 4);
        pcommit(0, 7'd8);
        wr(0, 4'd0, 32'hB0B0_B0B0);
        push(0, K_CACK, 4);
        pcommit(0, 7'd12);
        chk("t2_bcnt2", 32'(bcnt[0]), 2);
        chk("t2_ready0", 32'(ready[0]), 0);
        chk("t2_len8", 32'(ulen[0]), 8);
        push(0, K_OVR, 1);
        pcommit(0, 7'd20);
        chk("t3_bcnt_ovr", 32'(bcnt[0]), 2);
        chk("t3_len_ovr", 32'(ulen[0]), 8);
        wr(0, 4'd0, 32'hDEAD_DEAD);
        rd(0, 4'd0, 32'hB1B1_B1B1);
        push(0, K_RACK, 4);
        prel(0);
        chk("t2_bcnt1", 32'(bcnt[0]), 1);
        chk("t2_len12", 32'(ulen[0]), 12);
        rd(0, 4'd0, 32'hB0B0_B0B0);
        push(0, K_RACK, 4);
        prel(0);
        chk("t2_bcnt0", 32'(bcnt[0]), 0);
        chk("t2_hasdata0", 32'(hasdata[0]), 0);
        push(0, K_UND, 1);
        prel(0);
        chk("t3_bcnt_und", 32'(bcnt[0]), 0);

        // length clamp and writes dropped during the ack window
        wr(0, 4'd5, 32'h5555_5555);
        push(0, K_CACK, 4);
        clen[0]   = 7'd100;
        commit[0] = 1'b1;
        cyc(2);
        commit[0]  = 1'b0;
        wr_en[0]   = 1'b1;
        wr_addr[0] = 4'd5;
        wr_data[0] = 32'hBAD0_BAD0;
        cyc(3);
        wr_en[0] = 1'b0;
        cyc(1);
        chk("t4_clamp", 32'(ulen[0]), 64);
        rd(0, 4'd5, 32'h5555_5555);
        push(0, K_RACK, 4);
        prel(0);

        // single-buffer instance
        wr(1, 4'd3, 32'hC3C3_C3C3);
        push(1, K_CACK, 3);
        pcommit(1, 7'd4);
        chk("t5_bcnt1", 32'(bcnt[1]), 1);
        chk("t5_ready0", 32'(ready[1]), 0);
        chk("t5_len4", 32'(ulen[1]), 4);
        push(1, K_OVR, 1);
        pcommit(1, 7'd8);
        chk("t5_len_ovr", 32'(ulen[1]), 4);
        rd(1, 4'd3, 32'hC3C3_C3C3);
        push(1, K_RACK, 3);
        prel(1);
        chk("t5_ready1", 32'(ready[1]), 1);
        chk("t5_bcnt0", 32'(bcnt[1]), 0);
        wr(1, 4'd3, 32'hC4C4_C4C4);
        push(1, K_CACK, 3);
        pcommit(1, 7'd8);
        chk("t5_len8", 32'(ulen[1]), 8);
        rd(1, 4'd3, 32'hC4C4_C4C4);
        push(1, K_RACK, 3);
        prel(1);

        // reset in the second ack cycle, commit held across reset
        push(0, K_CACK, 2);
        clen[0]   = 7'd20;
        commit[0] = 1'b1;
        cyc(3);
        reset_n = 1'b0;
        cyc(1);
        chk("t6_ack_abort", 32'(pul[0][0]), 0);
        chk("t6_bcnt", 32'(bcnt[0]), 0);
        chk("t6_hasdata", 32'(hasdata[0]), 0);
        chk("t6_ready", 32'(ready[0]), 1);
        cyc(1);
        reset_n = 1'b1;
        push(0, K_CACK, 4);
        cyc(6);
        chk("t6_bcnt1", 32'(bcnt[0]), 1);
        chk("t6_len", 32'(ulen[0]), 20);
        cyc(4);
        chk("t6_once", 32'(bcnt[0]), 1);
        commit[0] = 1'b0;
        cyc(8);
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
